// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// Registered WIDTH-bit adder built from a ripple chain of 1-bit full-adder
// cells. It computes {Cout, S} = A + B + Cin with no loss of the carry, and
// it also flags two's-complement signed overflow. All outputs come from
// registers, so there is no combinational path from inputs to outputs. An
// operation accepted at clock edge N appears on the outputs right after
// edge N.
//
// Parameters
//   WIDTH        operand width in bits, 1..64
//   HOLD_ON_IDLE 1: S/Cout/ovf keep their value while in_valid=0
//                0: S/Cout/ovf register the current inputs every cycle
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst        in   synchronous active-high reset; overrides in_valid
//   A, B       in   WIDTH-bit addends (unsigned or two's complement)
//   Cin        in   carry-in, weight 2^0
//   S          out  registered sum bits
//   Cout       out  registered carry-out, weight 2^WIDTH
//   in_valid   in   qualifies A, B and Cin in the current cycle
//   out_valid  out  registered in_valid; high for one cycle per operation
//   ovf        out  registered signed overflow (carry into MSB ^ carry out)
// -----------------------------------------------------------------------------
module full_adder #(
    parameter int WIDTH        = 1,
    parameter int HOLD_ON_IDLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    input  logic             in_valid,
    output logic             out_valid,
    output logic             ovf
);

    // With holding disabled the result registers load on every cycle.
    localparam bit UPDATE_ALWAYS = (HOLD_ON_IDLE == 0);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic             sum_ovf;

    // Ripple chain: each bit is a 1-bit full adder. The sum bit is the
    // three-input xor and the carry-out is the majority of the three inputs.
    always_comb begin
        // NOTE: every variable gets a value before the loop, so no path
        // through this block leaves a signal unassigned and no latch is
        // inferred.
        carry    = '0;
        sum      = '0;
        carry[0] = Cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
        end
    end

    // Signed overflow happens when the carry into the sign bit differs from
    // the carry out of it. For WIDTH=1 the carry into the MSB is Cin itself.
    assign sum_ovf = carry[WIDTH-1] ^ carry[WIDTH];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. Every
        // register then samples its pre-edge value, whatever order the
        // statements are written in.
        if (rst) begin
            S         <= '0;
            Cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid || UPDATE_ALWAYS) begin
                S    <= sum;
                Cout <= carry[WIDTH];
                ovf  <= sum_ovf;
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//
// Self-checking bench for full_adder with three instances:
//   u_w1   WIDTH=1, HOLD_ON_IDLE=1
//   u_w8   WIDTH=8, HOLD_ON_IDLE=1
//   u_w4n  WIDTH=4, HOLD_ON_IDLE=0
// Inputs are driven on the falling edge. Outputs are sampled 1 ns after the
// rising edge. Every expected value below is worked out by hand.
// -----------------------------------------------------------------------------
module tb_full_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // WIDTH=1 instance
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, v1 = 1'b0;
    logic       s1, co1, ov1, ovf1;
    // WIDTH=8 instance
    logic [7:0] a8 = '0, b8 = '0;
    logic       c8 = 1'b0, v8 = 1'b0;
    logic [7:0] s8;
    logic       co8, ov8, ovf8;
    // WIDTH=4, no-hold instance
    logic [3:0] a4 = '0, b4 = '0;
    logic       c4 = 1'b0, v4 = 1'b0;
    logic [3:0] s4;
    logic       co4, ov4, ovf4;

    full_adder #(.WIDTH(1), .HOLD_ON_IDLE(1)) u_w1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1), .S(s1), .Cout(co1),
        .in_valid(v1), .out_valid(ov1), .ovf(ovf1)
    );

    full_adder #(.WIDTH(8), .HOLD_ON_IDLE(1)) u_w8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(c8), .S(s8), .Cout(co8),
        .in_valid(v8), .out_valid(ov8), .ovf(ovf8)
    );

    full_adder #(.WIDTH(4), .HOLD_ON_IDLE(0)) u_w4n (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(c4), .S(s4), .Cout(co4),
        .in_valid(v4), .out_valid(ov4), .ovf(ovf4)
    );

    int n_vectors   = 0;
    int n_miscompare = 0;

    // Expected values are packed as {out_valid, ovf, Cout, S}.

    task automatic test_reset();
        logic [3:0]  exp1 = 4'b0000;
        logic [10:0] exp8 = 11'h000;
        logic [6:0]  exp4 = 7'h00;
        rst = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vectors++;
        if ({ov1, ovf1, co1, s1} !== exp1) begin
            n_miscompare++;
            $display("FAIL reset_w1: got %b want %b", {ov1, ovf1, co1, s1}, exp1);
        end
        n_vectors++;
        if ({ov8, ovf8, co8, s8} !== exp8) begin
            n_miscompare++;
            $display("FAIL reset_w8: got %h want %h", {ov8, ovf8, co8, s8}, exp8);
        end
        n_vectors++;
        if ({ov4, ovf4, co4, s4} !== exp4) begin
            n_miscompare++;
            $display("FAIL reset_w4n: got %h want %h", {ov4, ovf4, co4, s4}, exp4);
        end
        @(negedge clk);
        rst = 1'b0;
        v1 = 1'b0; v8 = 1'b0; v4 = 1'b0;
    endtask

    // Exhaustive WIDTH=1 sweep, one operation per cycle. The first operation
    // after reset release must already complete in one cycle.
    task automatic test_w1_sweep();
        // {Cout,S} = 00,01,01,10,01,10,10,11 and ovf = Cin ^ Cout
        logic [2:0] exp_cs  [8] = '{3'b000, 3'b001, 3'b001, 3'b010,
                                    3'b001, 3'b010, 3'b010, 3'b011};
        logic       exp_ovf [8] = '{1'b0, 1'b1, 1'b0, 1'b0,
                                    1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] exp;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            {a1, b1, c1} = abc;
            v1 = 1'b1;
            @(posedge clk);
            #1;
            exp = {1'b1, exp_ovf[i], exp_cs[i][1:0]};
            n_vectors++;
            if ({ov1, ovf1, co1, s1} !== exp) begin
                n_miscompare++;
                $display("FAIL w1_sweep abc=%b: got {ov,ovf,co,s}=%b want %b",
                         abc, {ov1, ovf1, co1, s1}, exp);
            end
            @(negedge clk);
        end
        v1 = 1'b0;
    endtask

    // Back-to-back WIDTH=8 operations with hand-computed results.
    task automatic test_w8_vectors();
        logic [7:0]  va [6] = '{8'hFF, 8'h7F, 8'hFF, 8'h80, 8'h12, 8'hFF};
        logic [7:0]  vb [6] = '{8'h01, 8'h01, 8'hFF, 8'h80, 8'h34, 8'h00};
        logic        vc [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
        // {out_valid, ovf, Cout, S}
        logic [10:0] ve [6] = '{{1'b1, 1'b0, 1'b1, 8'h00},
                                {1'b1, 1'b1, 1'b0, 8'h80},
                                {1'b1, 1'b0, 1'b1, 8'hFF},
                                {1'b1, 1'b1, 1'b1, 8'h00},
                                {1'b1, 1'b0, 1'b0, 8'h47},
                                {1'b1, 1'b0, 1'b1, 8'h00}};
        for (int i = 0; i < 6; i++) begin
            a8 = va[i]; b8 = vb[i]; c8 = vc[i]; v8 = 1'b1;
            @(posedge clk);
            #1;
            n_vectors++;
            if ({ov8, ovf8, co8, s8} !== ve[i]) begin
                n_miscompare++;
                $display("FAIL w8_vec %0d (%h+%h+%b): got %h want %h",
                         i, va[i], vb[i], vc[i], {ov8, ovf8, co8, s8}, ve[i]);
            end
            @(negedge clk);
        end
        v8 = 1'b0;
    endtask

    // 1+1+0 on WIDTH=1 gives S=0, Cout=1, ovf=1. The result must then hold
    // through three idle cycles while the idle inputs would give 0+0+1.
    task automatic test_hold();
        logic [3:0] exp;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
        @(posedge clk);
        #1;
        exp = 4'b1110;
        n_vectors++;
        if ({ov1, ovf1, co1, s1} !== exp) begin
            n_miscompare++;
            $display("FAIL hold_load: got %b want %b", {ov1, ovf1, co1, s1}, exp);
        end
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b1; v1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            exp = 4'b0110;
            n_vectors++;
            if ({ov1, ovf1, co1, s1} !== exp) begin
                n_miscompare++;
                $display("FAIL hold_idle cycle %0d: got %b want %b",
                         k, {ov1, ovf1, co1, s1}, exp);
            end
            @(negedge clk);
        end
    endtask

    // HOLD_ON_IDLE=0: results follow the inputs even while in_valid is low.
    task automatic test_no_hold();
        logic [3:0] va [3] = '{4'h3, 4'hF, 4'h7};
        logic [3:0] vb [3] = '{4'h4, 4'h1, 4'h7};
        logic       vc [3] = '{1'b1, 1'b0, 1'b1};
        logic       vv [3] = '{1'b0, 1'b1, 1'b0};
        logic [6:0] ve [3] = '{{1'b0, 1'b1, 1'b0, 4'h8},
                               {1'b1, 1'b0, 1'b1, 4'h0},
                               {1'b0, 1'b1, 1'b0, 4'hF}};
        for (int i = 0; i < 3; i++) begin
            a4 = va[i]; b4 = vb[i]; c4 = vc[i]; v4 = vv[i];
            @(posedge clk);
            #1;
            n_vectors++;
            if ({ov4, ovf4, co4, s4} !== ve[i]) begin
                n_miscompare++;
                $display("FAIL no_hold %0d: got %h want %h",
                         i, {ov4, ovf4, co4, s4}, ve[i]);
            end
            @(negedge clk);
        end
        v4 = 1'b0;
    endtask

    // Reset in the middle of a valid stream discards that cycle's operation.
    // The next operation must complete with normal latency.
    task automatic test_back_to_back_reset();
        logic [10:0] exp;
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; v8 = 1'b1;
        @(posedge clk);
        #1;
        exp = {1'b1, 1'b0, 1'b0, 8'h30};
        n_vectors++;
        if ({ov8, ovf8, co8, s8} !== exp) begin
            n_miscompare++;
            $display("FAIL b2b_pre: got %h want %h", {ov8, ovf8, co8, s8}, exp);
        end
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; c8 = 1'b0; v8 = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        exp = 11'h000;
        n_vectors++;
        if ({ov8, ovf8, co8, s8} !== exp) begin
            n_miscompare++;
            $display("FAIL b2b_rst: got %h want %h", {ov8, ovf8, co8, s8}, exp);
        end
        @(negedge clk);
        rst = 1'b0;
        a8 = 8'h05; b8 = 8'h06; c8 = 1'b1; v8 = 1'b1;
        @(posedge clk);
        #1;
        exp = {1'b1, 1'b0, 1'b0, 8'h0C};
        n_vectors++;
        if ({ov8, ovf8, co8, s8} !== exp) begin
            n_miscompare++;
            $display("FAIL b2b_post: got %h want %h", {ov8, ovf8, co8, s8}, exp);
        end
        @(negedge clk);
        v8 = 1'b0;
        @(posedge clk);
        #1;
        exp = {1'b0, 1'b0, 1'b0, 8'h0C};
        n_vectors++;
        if ({ov8, ovf8, co8, s8} !== exp) begin
            n_miscompare++;
            $display("FAIL b2b_idle: got %h want %h", {ov8, ovf8, co8, s8}, exp);
        end
    endtask

    initial begin
        test_reset();
        test_w1_sweep();
        test_w8_vectors();
        test_hold();
        test_no_hold();
        test_back_to_back_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
        $finish;
    end

endmodule
